modulo_controle_transferencia_rolhas: RTL and testbench

- Controller for the cork datapath.
- Owns the main cork register (principal, 0..99) and the secondary reservoir register (secundario, 0..99).
- Arbitrates three requesters that want to change them: the sealing step consuming one cork per bottle, automatic refill from secondary to main, and the operator's manual transfer request.
- Sits between the filling/sealing FSM (ve handshake), the cork-entry counter (sec_load) and the display encoders (principal/secundario outputs).

---
 rtl/modulo_controle_transferencia_rolhas_if.sv | 47 ++++
 rtl/modulo_controle_transferencia_rolhas.sv | 158 +++++++++++++++
 tb/tb_modulo_controle_transferencia_rolhas.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/modulo_controle_transferencia_rolhas_if.sv
// Cork-controller bus: enable, sealing handshake, operator request,
// secondary-load port and the register/status outputs.
// Optional feature macro: ROLHAS_ESTATISTICA_EN adds total_transf.
interface modulo_controle_transferencia_rolhas_if #(
    parameter int WIDTH = 7
);
    logic             enable;
    logic             ve_req;
    logic             ve_ack;
    logic             op_req;
    logic             sec_load;
    logic [WIDTH-1:0] sec_qtd;
    logic [WIDTH-1:0] principal;
    logic [WIDTH-1:0] secundario;
    logic             ro;
    logic             min_r;
    logic             alarme;
    logic             transf_done;
    logic [1:0]       estado;
`ifdef ROLHAS_ESTATISTICA_EN
    logic [15:0]      total_transf;

    modport slave (
        input  enable, ve_req, op_req, sec_load, sec_qtd,
        output ve_ack, principal, secundario, ro, min_r, alarme,
               transf_done, estado, total_transf
    );

    modport master (
        output enable, ve_req, op_req, sec_load, sec_qtd,
        input  ve_ack, principal, secundario, ro, min_r, alarme,
               transf_done, estado, total_transf
    );
`else
    modport slave (
        input  enable, ve_req, op_req, sec_load, sec_qtd,
        output ve_ack, principal, secundario, ro, min_r, alarme,
               transf_done, estado
    );

    modport master (
        output enable, ve_req, op_req, sec_load, sec_qtd,
        input  ve_ack, principal, secundario, ro, min_r, alarme,
               transf_done, estado
    );
`endif
endinterface

// File: rtl/modulo_controle_transferencia_rolhas.sv
// Cork transfer controller: owns the main (principal) and secondary
// (secundario) cork registers and arbitrates sealing consumption,
// automatic/operator refill batches and secondary loading.
// Optional feature macro: ROLHAS_ESTATISTICA_EN adds the total_transf
// counter of corks moved secondary->main.
module modulo_controle_transferencia_rolhas #(
    parameter int WIDTH         = 7,
    parameter int MAX_PRINCIPAL = 99,
    parameter int MIN_PRINCIPAL = 5,
    parameter int LOTE          = 15
) (
    input  logic clk,
    input  logic clr,
    modulo_controle_transferencia_rolhas_if.slave bus
);

    localparam int               LW    = $clog2(LOTE + 1);
    localparam logic [WIDTH-1:0] MAX_P = WIDTH'(MAX_PRINCIPAL);
    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PRINCIPAL);
    localparam logic [LW-1:0]    LOTE_V = LW'(LOTE);

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        TRANSFERE = 2'b01,
        CONCLUI   = 2'b10,
        BLOQUEADO = 2'b11
    } estado_t;

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] principal_q, principal_d;
    logic [WIDTH-1:0] secundario_q, secundario_d;
    logic [LW-1:0]    lote_q, lote_d;
    logic             ve_ack_q, ve_ack_d;
    logic             grant;
    logic             move;
    logic             min_r_w;
    logic [WIDTH:0]   sec_sum;

    assign min_r_w = (principal_q < MIN_P);

    // Consumption wins every cycle; a grant is never issued while the
    // previous ack is still visible, so at most one cork per two cycles.
    assign grant = bus.enable && bus.ve_req && !ve_ack_q && (principal_q != '0);

    // A refill move only happens in TRANSFERE cycles without a grant.
    assign move  = bus.enable && (state_q == TRANSFERE) && !grant &&
                   (secundario_q != '0) && (principal_q < MAX_P);

    // Register datapath: consumption/move on principal, move and load on
    // secundario with saturation computed one bit wider.
    always_comb begin
        principal_d  = principal_q;
        secundario_d = secundario_q;
        sec_sum      = {1'b0, secundario_q};
        ve_ack_d     = grant;
        if (bus.enable) begin
            if (grant) begin
                principal_d = principal_q - 1'b1;
            end else if (move) begin
                principal_d = principal_q + 1'b1;
            end
            sec_sum = {1'b0, secundario_q} - {{WIDTH{1'b0}}, move} +
                      (bus.sec_load ? {1'b0, bus.sec_qtd} : '0);
            secundario_d = (sec_sum > {1'b0, MAX_P}) ? MAX_P : sec_sum[WIDTH-1:0];
        end
    end

    // Transfer FSM next state and batch counter.
    always_comb begin
        state_d = state_q;
        lote_d  = lote_q;
        if (bus.enable) begin
            if (move) begin
                lote_d = lote_q + 1'b1;
            end
            unique case (state_q)
                OCIOSO: begin
                    if ((min_r_w || bus.op_req) && (secundario_q != '0) &&
                        (principal_q < MAX_P)) begin
                        state_d = TRANSFERE;
                        lote_d  = '0;
                    end else if (min_r_w && (secundario_q == '0)) begin
                        state_d = BLOQUEADO;
                    end
                end
                TRANSFERE: begin
                    if (move) begin
                        if ((lote_d == LOTE_V) || (principal_d == MAX_P) ||
                            (secundario_d == '0)) begin
                            state_d = CONCLUI;
                        end
                    end else if (!grant) begin
                        // Nothing left to move: close the batch.
                        state_d = CONCLUI;
                    end
                end
                CONCLUI: begin
                    state_d = OCIOSO;
                end
                BLOQUEADO: begin
                    if ((secundario_q != '0) || !min_r_w) begin
                        state_d = OCIOSO;
                    end
                end
            endcase
        end
    end

    // State registers; _d values already hold when enable is low.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= OCIOSO;
            principal_q  <= '0;
            secundario_q <= '0;
            lote_q       <= '0;
            ve_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            principal_q  <= principal_d;
            secundario_q <= secundario_d;
            lote_q       <= lote_d;
            ve_ack_q     <= ve_ack_d;
        end
    end

`ifdef ROLHAS_ESTATISTICA_EN
    logic [15:0] total_q, total_d;

    // Saturating count of corks moved secondary->main.
    always_comb begin
        total_d = total_q;
        if (move && (total_q != 16'hFFFF)) begin
            total_d = total_q + 16'd1;
        end
    end

    // Statistics register.
    always_ff @(posedge clk) begin
        if (clr) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign bus.total_transf = total_q;
`endif

    assign bus.ve_ack      = ve_ack_q && bus.enable;
    assign bus.transf_done = (state_q == CONCLUI) && bus.enable;
    assign bus.alarme      = (state_q == BLOQUEADO);
    assign bus.estado      = state_q;
    assign bus.principal   = principal_q;
    assign bus.secundario  = secundario_q;
    assign bus.ro          = (principal_q == '0);
    assign bus.min_r       = min_r_w;

endmodule

// File: tb/tb_modulo_controle_transferencia_rolhas.sv
// Self-checking bench for modulo_controle_transferencia_rolhas: directed
// steps followed by a randomized phase, compared against a cycle model.
module tb_modulo_controle_transferencia_rolhas;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    modulo_controle_transferencia_rolhas_if #(.WIDTH(7)) ctl ();

    modulo_controle_transferencia_rolhas dut (
        .clk (clk),
        .clr (clr),
        .bus (ctl)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state (0=idle,1=transfer,2=done,3=blocked)
    int m_state, m_p, m_s, m_lote, m_ack, m_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int g, mv, np, ns;
        if (clr) begin
            m_state = 0; m_p = 0; m_s = 0; m_lote = 0; m_ack = 0; m_total = 0;
            return;
        end
        if (!ctl.enable) begin
            m_ack = 0;
            return;
        end
        g  = (ctl.ve_req && m_ack == 0 && m_p > 0) ? 1 : 0;
        mv = (m_state == 1 && g == 0 && m_s > 0 && m_p < 99) ? 1 : 0;
        np = m_p - g + mv;
        ns = m_s - mv + (ctl.sec_load ? int'(ctl.sec_qtd) : 0);
        if (ns > 99) ns = 99;
        case (m_state)
            0: begin
                if ((m_p < 5 || ctl.op_req) && m_s > 0 && m_p < 99) begin
                    m_state = 1; m_lote = 0;
                end else if (m_p < 5 && m_s == 0) begin
                    m_state = 3;
                end
            end
            1: if (mv == 1) begin
                m_lote++;
                if (m_lote == 15 || np == 99 || ns == 0) m_state = 2;
            end
            2: m_state = 0;
            default: if (m_s > 0 || m_p >= 5) m_state = 0;
        endcase
        m_p = np; m_s = ns; m_ack = g;
        if (mv == 1 && m_total < 65535) m_total++;
    endtask

    task automatic check_all();
        check("principal",   ctl.principal,   m_p);
        check("secundario",  ctl.secundario,  m_s);
        check("ve_ack",      ctl.ve_ack,      (m_ack == 1 && ctl.enable) ? 1 : 0);
        check("ro",          ctl.ro,          (m_p == 0) ? 1 : 0);
        check("min_r",       ctl.min_r,       (m_p < 5) ? 1 : 0);
        check("alarme",      ctl.alarme,      (m_state == 3) ? 1 : 0);
        check("transf_done", ctl.transf_done, (m_state == 2 && ctl.enable) ? 1 : 0);
        check("estado",      ctl.estado,      m_state);
`ifdef ROLHAS_ESTATISTICA_EN
        check("total_transf", ctl.total_transf, m_total);
`endif
    endtask

    // One clock: model advances with the inputs present before the edge,
    // outputs compared on the following falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_until_done(input int max_cycles);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < max_cycles && !hit; i++) begin
            tick();
            if (m_state == 2 && ctl.enable) hit = 1'b1;
        end
        check("done_within_bound", hit, 1);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_op();
        ctl.op_req = 1'b1;
        tick();
        ctl.op_req = 1'b0;
    endtask

    task automatic load_sec(input int q);
        ctl.sec_load = 1'b1;
        ctl.sec_qtd  = 7'(q);
        tick();
        ctl.sec_load = 1'b0;
    endtask

    initial begin
        clr = 1'b0;
        ctl.enable = 1'b0; ctl.ve_req = 1'b0; ctl.op_req = 1'b0;
        ctl.sec_load = 1'b0; ctl.sec_qtd = '0;
        m_state = 0; m_p = 0; m_s = 0; m_lote = 0; m_ack = 0; m_total = 0;
        @(negedge clk);

        // Reset values
        do_clear();
        check("rst_principal", ctl.principal, 0);
        check("rst_ro", ctl.ro, 1);
        check("rst_min_r", ctl.min_r, 1);
        check("rst_estado", ctl.estado, 0);
        check("rst_alarme", ctl.alarme, 0);

        // 1: initial refill of one full batch
        ctl.enable = 1'b1;
        load_sec(40);
        run_until_done(60);
        check("t1_principal", ctl.principal, 15);
        check("t1_secundario", ctl.secundario, 25);
        repeat (3) tick();
        check("t1_idle", ctl.estado, 0);

        // 2: sustained consumption, refill interleaved with grants
        ctl.ve_req = 1'b1;
        repeat (40) tick();
        ctl.ve_req = 1'b0;
        repeat (20) tick();

        // 3: blocked with empty secondary, then recovery
        do_clear();
        ctl.enable = 1'b1;
        load_sec(3);
        repeat (12) tick();
        check("t3_alarme", ctl.alarme, 1);
        check("t3_estado", ctl.estado, 3);
        check("t3_principal", ctl.principal, 3);
        load_sec(10);
        run_until_done(40);
        check("t3_principal_end", ctl.principal, 13);
        check("t3_secundario_end", ctl.secundario, 0);
        tick();

        // 4: operator batches up to the ceiling, then op_req ignored
        for (int k = 0; k < 10 && m_p < 99; k++) begin
            load_sec(99);
            pulse_op();
            run_until_done(40);
            tick();
        end
        check("t4_principal_max", ctl.principal, 99);
        pulse_op();
        check("t4_op_ignored", ctl.estado, 0);
        check("t4_principal_hold", ctl.principal, 99);

        // 5: load saturation during transfer, freeze with enable low
        do_clear();
        ctl.enable = 1'b1;
        load_sec(99);
        repeat (3) tick();
        load_sec(10);
        check("t5_sec_sat", ctl.secundario, 99);
        check("t5_principal", ctl.principal, 2);
        ctl.enable = 1'b0;
        ctl.ve_req = 1'b1;
        repeat (3) tick();
        pulse_op();
        check("t5_frozen_p", ctl.principal, 2);
        check("t5_frozen_st", ctl.estado, 1);
        check("t5_no_ack", ctl.ve_ack, 0);
        ctl.ve_req = 1'b0;
        ctl.enable = 1'b1;
        run_until_done(40);
        check("t5_lote_kept", ctl.principal, 15);

        // 6: empty principal never acks; clr mid-transfer
        do_clear();
        ctl.enable = 1'b1;
        ctl.ve_req = 1'b1;
        repeat (3) tick();
        check("t6_no_ack", ctl.ve_ack, 0);
        check("t6_ro", ctl.ro, 1);
        ctl.ve_req = 1'b0;
        load_sec(20);
        repeat (4) tick();
        check("t6_in_transfer", ctl.estado, 1);
        do_clear();
        check("t6_clr_p", ctl.principal, 0);
        check("t6_clr_s", ctl.secundario, 0);
        check("t6_clr_estado", ctl.estado, 0);

        // Randomized phase
        for (int i = 0; i < 800; i++) begin
            ctl.enable   = ($urandom_range(0, 15) != 0);
            clr          = ($urandom_range(0, 299) == 0);
            ctl.op_req   = ($urandom_range(0, 9) == 0);
            ctl.sec_load = ($urandom_range(0, 9) == 0);
            ctl.sec_qtd  = 7'($urandom_range(0, 127));
            if (!ctl.ve_req || (m_ack == 1 && ctl.enable))
                ctl.ve_req = ($urandom_range(0, 2) == 0);
            tick();
        end
        clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
